// File: rtl/mult_div_unit_pkg.sv
// Shared MDU definitions: MDUOp encodings and default latencies.
// Also used by the decoder to form its MDUClass signal.
package mult_div_unit_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO.
// Fixed-latency ops; result is held until the counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        IntExcReq,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic               is_arith, is_div, div_zero, mt_en;
  logic signed [32:0] sa, sb, sq, sr;
  logic        [32:0] ua, ub, uq, ur;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               unused_bits;

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  assign is_arith = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU) ||
                    (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);
  assign is_div   = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
  assign Start    = is_arith && !Busy && !IntExcReq;
  assign mt_en    = !Busy && !IntExcReq;
  assign div_zero = (B == 32'd0);

  // Divisor forced to 1 on zero so the dividers never see x/0.
  assign sa = {A[31], A};
  assign sb = div_zero ? 33'sd1 : {B[31], B};
  assign ua = {1'b0, A};
  assign ub = div_zero ? 33'd1 : {1'b0, B};
  assign sq = sa / sb;
  assign sr = sa % sb;
  assign uq = ua / ub;
  assign ur = ua % ub;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  assign unused_bits = ^{sq[32], sr[32], uq[32], ur[32]};

  always_comb begin
    res_d = 64'd0;
    unique case (MDUOp)
      MDU_MULT:  res_d = prod_s;
      MDU_MULTU: res_d = prod_u;
      MDU_DIV:   res_d = {sr[31:0], sq[31:0]};
      MDU_DIVU:  res_d = {ur[31:0], uq[31:0]};
      default:   res_d = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
          wr_d    = !(is_div && div_zero);
        end else if (mt_en && MDUOp == MDU_MTHI) begin
          hi_d = A;
        end else if (mt_en && MDUOp == MDU_MTLO) begin
          lo_d = A;
        end
      end
      RUN: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (Start) res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit.
// Directed cases plus randomized ops against a reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUOp;
  logic        IntExcReq;
  logic        Start, Busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .A(A), .B(B),
    .MDUOp(MDUOp), .IntExcReq(IntExcReq),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] hi,
                                inout logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MDU_MULT: begin
        q = sa * sb;
        hi = q[63:32]; lo = q[31:0];
      end
      MDU_MULTU: begin
        p = ua * ub;
        hi = p[63:32]; lo = p[31:0];
      end
      MDU_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        hi = r[31:0]; lo = q[31:0];
      end
      MDU_DIVU: if (b != 0) begin
        p = ua / ub; hi = 32'(ua % ub); lo = p[31:0];
      end
      MDU_MTHI: hi = a;
      MDU_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op);
    return (op == MDU_DIV || op == MDU_DIVU) ? 10 : 5;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic st);
    @(negedge clk);
    A = a; B = b; MDUOp = op;
    #1 st = Start;
    @(posedge clk);
    #1 MDUOp = MDU_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 60) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; A = 0; B = 0; MDUOp = MDU_NONE; IntExcReq = 0;
    #12;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset: Busy=%b HI=%h LO=%h want 0", Busy, HI, LO);
    end
    MDUOp = MDU_MTLO; #1;
    checks++;
    if (Start !== 1'b0) begin
      errors++;
      $display("FAIL reset_start: Start=%b want 0", Start);
    end
    MDUOp = MDU_NONE;
    @(negedge clk) reset = 1'b0;
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [7] = '{MDU_MULT, MDU_MULTU, MDU_DIVU, MDU_DIV,
                             MDU_DIV, MDU_MULT, MDU_DIVU};
    logic [31:0] as  [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd7,
                             32'hFFFFFFF9, 32'h80000000, 32'h7FFFFFFF,
                             32'h12345678};
    logic [31:0] bs  [7] = '{32'd5, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF,
                             32'h80000000, 32'd1};
    logic [31:0] eh  [7] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFF,
                             32'h0, 32'hC0000000, 32'h0};
    logic [31:0] el  [7] = '{32'hFFFFFFF1, 32'hFFFFFFFE, 32'h3,
                             32'hFFFFFFFD, 32'h80000000, 32'h80000000,
                             32'h12345678};
    logic st;
    int n;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i], st);
      checks++;
      if (st !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_start: Start=%b want 1", i, st);
      end
      wait_idle(n);
      checks++;
      if (n != lat(ops[i])) begin
        errors++;
        $display("FAIL dir%0d_busy: cycles=%0d want %0d", i, n, lat(ops[i]));
      end
      checks++;
      if (HI !== eh[i] || LO !== el[i]) begin
        errors++;
        $display("FAIL dir%0d_res: HI=%h LO=%h want %h %h",
                 i, HI, LO, eh[i], el[i]);
      end
      m_hi = eh[i]; m_lo = el[i];
    end
  endtask

  task automatic test_div_zero;
    logic st;
    int n;
    issue(MDU_MTHI, 32'h11, 0, st);
    issue(MDU_MTLO, 32'h22, 0, st);
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_preload: HI=%h LO=%h Busy=%b want 11 22 0",
               HI, LO, Busy);
    end
    issue(MDU_DIVU, 32'd99, 32'd0, st);
    wait_idle(n);
    checks++;
    if (n != 10 || HI !== 32'h11 || LO !== 32'h22) begin
      errors++;
      $display("FAIL divzero: cycles=%0d HI=%h LO=%h want 10 11 22",
               n, HI, LO);
    end
    m_hi = 32'h11; m_lo = 32'h22;
  endtask

  task automatic test_irq;
    @(negedge clk);
    A = 32'd6; B = 32'd7; MDUOp = MDU_MULT; IntExcReq = 1'b1;
    #1;
    checks++;
    if (Start !== 1'b0) begin
      errors++;
      $display("FAIL irq_start: Start=%b want 0", Start);
    end
    @(negedge clk);
    MDUOp = MDU_MTHI; A = 32'hDEAD;
    @(negedge clk);
    MDUOp = MDU_NONE; IntExcReq = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
      errors++;
      $display("FAIL irq_state: Busy=%b HI=%h LO=%h want 0 %h %h",
               Busy, HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back;
    logic st;
    int n;
    issue(MDU_MULT, 32'd6, 32'd7, st);
    @(negedge clk);
    A = 32'd100; B = 32'd100; MDUOp = MDU_MULTU;
    #1;
    checks++;
    if (Start !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: Start=%b Busy=%b want 0 1", Start, Busy);
    end
    @(negedge clk) MDUOp = MDU_MTLO; A = 32'hBAD;
    @(negedge clk) IntExcReq = 1'b1; MDUOp = MDU_NONE;
    @(negedge clk) IntExcReq = 1'b0;
    #1 wait_idle(n);
    checks++;
    if (HI !== 32'd0 || LO !== 32'd42) begin
      errors++;
      $display("FAIL b2b_res: HI=%h LO=%h want 0 2a", HI, LO);
    end
    m_hi = 0; m_lo = 32'd42;
  endtask

  task automatic test_reset_midrun;
    logic st;
    int n;
    issue(MDU_DIV, 32'd1000, 32'd3, st);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: Busy=%b want 1", Busy);
    end
    @(negedge clk) reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset: Busy=%b HI=%h LO=%h want 0", Busy, HI, LO);
    end
    @(negedge clk) reset = 1'b0;
    issue(MDU_MULTU, 32'd3, 32'd4, st);
    wait_idle(n);
    checks++;
    if (n != 5 || HI !== 32'd0 || LO !== 32'd12) begin
      errors++;
      $display("FAIL midrun_fresh: cycles=%0d HI=%h LO=%h want 5 0 c",
               n, HI, LO);
    end
    m_hi = 0; m_lo = 32'd12;
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic st;
    int n;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      issue(op, a, b, st);
      model(op, a, b, m_hi, m_lo);
      if (op <= MDU_DIVU) begin
        wait_idle(n);
        checks++;
        if (n != lat(op)) begin
          errors++;
          $display("FAIL rnd%0d_busy: cycles=%0d want %0d", i, n, lat(op));
        end
      end
      checks++;
      if (HI !== m_hi || LO !== m_lo) begin
        errors++;
        $display("FAIL rnd%0d op%0d a=%h b=%h: HI=%h LO=%h want %h %h",
                 i, op, a, b, HI, LO, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_irq;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
